// File: rtl/imem_loader.sv
// Program loader: turns a length-prefixed big-endian byte stream into sequential
// instruction-memory word writes and holds the processor in reset until loading ends.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned MAX_WORDS  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_HDR_HI = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_WORD   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [7:0]       hdr_hi;
    logic [CNT_W-1:0] word_n;
    logic [CNT_W-1:0] word_cnt;
    logic [1:0]       byte_idx;
    logic [23:0]      shift_q;

    logic             xfer_c;
    logic [CNT_W-1:0] hdr_n_c;
    logic             last_word_c;

    assign xfer_c      = in_valid && in_ready;
    assign hdr_n_c     = {hdr_hi, in_data};
    assign last_word_c = (word_cnt == word_n - CNT_W'(1));

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_HDR_HI: begin
                if (xfer_c) state_nxt = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (xfer_c) begin
                    if (hdr_n_c == '0)
                        state_nxt = S_DONE;
                    else if (hdr_n_c > CNT_W'(MAX_WORDS))
                        state_nxt = S_ERROR;
                    else
                        state_nxt = S_WORD;
                end
            end
            S_WORD: begin
                if (xfer_c && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                state_nxt = last_word_c ? S_DONE : S_WORD;
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERROR: state_nxt = S_ERROR;
            default: state_nxt = S_HDR_HI;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_HDR_HI;
        else       state <= state_nxt;
    end

    // Handshake and status outputs; done/error/cpu_reset follow the state one edge later
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b0;
            imem_we   <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == S_HDR_HI) || (state_nxt == S_HDR_LO) ||
                         (state_nxt == S_WORD);
            imem_we   <= (state_nxt == S_WRITE);
            cpu_reset <= (state != S_DONE);
            done      <= (state == S_DONE);
            error     <= (state == S_ERROR);
        end
    end

    // Header capture, word assembly and write addressing
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_hi     <= '0;
            word_n     <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            shift_q    <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            case (state)
                S_HDR_HI: begin
                    if (xfer_c) hdr_hi <= in_data;
                end
                S_HDR_LO: begin
                    if (xfer_c) begin
                        word_n   <= hdr_n_c;
                        byte_idx <= '0;
                    end
                end
                S_WORD: begin
                    if (xfer_c) begin
                        shift_q  <= {shift_q[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) imem_wdata <= {shift_q, in_data};
                    end
                end
                S_WRITE: begin
                    // Address advances only when another word follows, so it never wraps
                    if (!last_word_c) begin
                        imem_addr <= imem_addr + ADDR_WIDTH'(1);
                        word_cnt  <= word_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed byte streams, expected writes queued in a scoreboard
// and checked by a negedge monitor whenever imem_we is high.
module tb_imem_loader;

    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_xfer = 0;
    int wcount = 0;
    logic prev_we = 1'b0;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [AW+31:0] sb_q [$];

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(64)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard and last one cycle
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            logic [AW+31:0] e;
            chk("we_pulse_len", {31'd0, prev_we}, 32'd0);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", {26'd0, imem_addr}, {26'd0, e[AW+31:32]});
                chk("wr_data", imem_wdata, e[31:0]);
            end
            mem[imem_addr] = imem_wdata;
            wcount++;
            chk("we_rdy_excl", {31'd0, in_ready}, 32'd0);
        end
        prev_we = imem_we;
    end

    task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned pct);
        int unsigned waited = 0;
        forever begin
            @(negedge clk);
            in_data  = b;
            in_valid = ($urandom_range(99) < pct);
            if (in_valid && in_ready) begin
                @(posedge clk);
                last_xfer = cyc;
                return;
            end
            waited++;
            if (waited > 2000) begin
                fails++;
                $display("FAIL send_byte_timeout: got no transfer expected transfer of %h", b);
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $fatal(1);
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned pct);
        send_byte(w[31:24], pct);
        send_byte(w[23:16], pct);
        send_byte(w[15:8], pct);
        send_byte(w[7:0], pct);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {26'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
        chk({name, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    endtask

    initial begin
        int k0;
        int wc0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hxxxxxxxx;

        // Reset values
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b0;

        // Two words, no gaps
        expect_wr(6'd0, 32'h20080005);
        expect_wr(6'd1, 32'h2009000A);
        send_byte(8'h00, 100);
        send_byte(8'h02, 100);
        send_word(32'h20080005, 100);
        send_word(32'h2009000A, 100);
        @(negedge clk);
        in_valid = 1'b0;
        chk("a_we_last", {31'd0, imem_we}, 32'd1);
        chk("a_ready_in_write", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("a_done_k1", {31'd0, done}, 32'd0);
        chk("a_cpurst_k1", {31'd0, cpu_reset}, 32'd1);
        @(negedge clk);
        chk("a_done_k2", {31'd0, done}, 32'd1);
        chk("a_cpurst_k2", {31'd0, cpu_reset}, 32'd0);
        chk("a_ready_done", {31'd0, in_ready}, 32'd0);
        chk("a_mem0", mem[0], 32'h20080005);
        chk("a_mem1", mem[1], 32'h2009000A);
        chk("a_sb_empty", sb_q.size(), 32'd0);

        // Empty program
        do_reset();
        wc0 = wcount;
        send_byte(8'h00, 100);
        send_byte(8'h00, 100);
        @(negedge clk);
        in_valid = 1'b0;
        chk("z_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_cpurst", {31'd0, cpu_reset}, 32'd0);
        repeat (3) @(negedge clk);
        chk("z_no_writes", wcount, wc0);

        // Oversized header
        do_reset();
        wc0 = wcount;
        send_byte(8'h00, 100);
        send_byte(8'h41, 100);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("e_error", {31'd0, error}, 32'd1);
        chk("e_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("e_ready", {31'd0, in_ready}, 32'd0);
        chk("e_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_data = 8'(i);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("e_no_writes", wcount, wc0);
        chk("e_error_sticky", {31'd0, error}, 32'd1);

        // Three words with sparse in_valid
        do_reset();
        for (int i = 0; i < 3; i++) mem[i] = 32'hxxxxxxxx;
        expect_wr(6'd0, 32'h20080005);
        expect_wr(6'd1, 32'h2009000A);
        expect_wr(6'd2, 32'h01095020);
        send_byte(8'h00, 30);
        send_byte(8'h03, 30);
        send_word(32'h20080005, 30);
        send_word(32'h2009000A, 30);
        send_word(32'h01095020, 30);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("g_done");
        chk("g_mem0", mem[0], 32'h20080005);
        chk("g_mem1", mem[1], 32'h2009000A);
        chk("g_mem2", mem[2], 32'h01095020);
        chk("g_sb_empty", sb_q.size(), 32'd0);

        // Byte held valid through WRITE is taken on the following cycle
        do_reset();
        expect_wr(6'd0, 32'h01020304);
        expect_wr(6'd1, 32'hAABBCCDD);
        send_byte(8'h00, 100);
        send_byte(8'h02, 100);
        send_word(32'h01020304, 100);
        k0 = last_xfer;
        @(negedge clk);
        in_data = 8'hAA;
        in_valid = 1'b1;
        chk("h_ready_write", {31'd0, in_ready}, 32'd0);
        send_byte(8'hAA, 100);
        chk("h_aa_latency", last_xfer - k0, 32'd2);
        send_byte(8'hBB, 100);
        send_byte(8'hCC, 100);
        send_byte(8'hDD, 100);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("h_done");
        chk("h_sb_empty", sb_q.size(), 32'd0);

        // Reset in the middle of the second word, then a fresh one-word program
        do_reset();
        expect_wr(6'd0, 32'h11223344);
        send_byte(8'h00, 100);
        send_byte(8'h02, 100);
        send_word(32'h11223344, 100);
        send_byte(8'h55, 100);
        send_byte(8'h66, 100);
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b0;
        expect_wr(6'd0, 32'h12345678);
        send_byte(8'h00, 100);
        send_byte(8'h01, 100);
        send_word(32'h12345678, 100);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("r_done");
        chk("r_mem0", mem[0], 32'h12345678);
        chk("r_sb_empty", sb_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
